// File: rtl/certificate_responder_if.sv
// Handshake/payload bundle between the certificate initiator and responder.
//   master : initiator side, drives Enable/Request/slot/Payload_Ack
//   slave  : responder side, drives the payload stream and status pulses
`ifndef MSG_LEN
`define MSG_LEN 64
`endif
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 2
`endif
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 8
`endif

interface certificate_responder_if #(
  parameter int unsigned PAYLOAD_W = `MSG_LEN-(`SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES)
);
  logic                 Enable;
  logic                 Request;
  logic [1:0]           slot;
  logic                 Payload_Ack;
  logic [PAYLOAD_W-1:0] Payload_out;
  logic                 Payload_Valid;
  logic [7:0]           counter_out;
  logic                 Last_Chunk;
  logic                 Busy;
  logic                 Done;
  logic                 Error_Invalid_Slot;
  logic                 Error_Timeout;

  modport master (
    output Enable, Request, slot, Payload_Ack,
    input  Payload_out, Payload_Valid, counter_out, Last_Chunk,
    input  Busy, Done, Error_Invalid_Slot, Error_Timeout
  );

  modport slave (
    input  Enable, Request, slot, Payload_Ack,
    output Payload_out, Payload_Valid, counter_out, Last_Chunk,
    output Busy, Done, Error_Invalid_Slot, Error_Timeout
  );
endinterface

// File: rtl/certificate_responder.sv
// Responder end of the certificate exchange: on an accepted Request, streams the
// requested slot's certificate chain one chunk per valid/ack transfer.
// Ports:
//   clk   - single clock, posedge
//   Reset - synchronous, active-high
//   bus   - certificate_responder_if.slave (request in, payload stream / status out)
// Parameter TIMEOUT_CYCLES bounds the wait for Payload_Ack per chunk (0 disables it).
`ifndef MSG_LEN
`define MSG_LEN 64
`endif
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 2
`endif
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 8
`endif
`ifndef SLOT0_CERT1
`define SLOT0_CERT1 48'h00C1_DEAD_BEEF
`define SLOT0_CERT2 48'h00C2_0BAD_F00D
`define SLOT0_CERT3 48'h00C3_1357_9BDF
`define SLOT0_CERT4 48'h00C4_2468_ACE0
`define SLOT0_CERT5 48'h00C5_FFFF_0000
`define SLOT0_CERT6 48'h00C6_8001_7FFE
`define SLOT1_CERT1 48'h01C1_A5A5_5A5A
`define SLOT1_CERT2 48'h01C2_CAFE_BABE
`define SLOT1_CERT3 48'h01C3_0F0F_F0F0
`define SLOT1_CERT4 48'h01C4_1111_2222
`define SLOT2_CERT1 48'h02C1_3333_4444
`define SLOT2_CERT2 48'h02C2_5555_6666
`define SLOT2_CERT3 48'h02C3_7777_8888
`define SLOT2_CERT4 48'h02C4_9999_AAAA
`define SLOT2_CERT5 48'h02C5_BBBB_CCCC
`endif

module certificate_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   Reset,
  certificate_responder_if.slave bus
);

  localparam int unsigned PAYLOAD_W = `MSG_LEN-(`SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES);
  localparam int unsigned N_SLOT0   = 6;
  localparam int unsigned N_SLOT1   = 4;
  localparam int unsigned N_SLOT2   = 5;
  localparam int unsigned WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Wait count at which one more un-acked cycle expires the chunk.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE, ERR} state_t;

  state_t            state;
  logic [1:0]        slot_q;
  logic [WAIT_W-1:0] wait_cnt;

  // Chain length of a slot; slot 3 has no chain.
  function automatic logic [7:0] chain_len(input logic [1:0] s);
    case (s)
      2'd0:    chain_len = 8'(N_SLOT0);
      2'd1:    chain_len = 8'(N_SLOT1);
      2'd2:    chain_len = 8'(N_SLOT2);
      default: chain_len = 8'd0;
    endcase
  endfunction

  // Certificate chunk c (1-based) of slot s.
  function automatic logic [PAYLOAD_W-1:0] cert(input logic [1:0] s, input logic [7:0] c);
    case ({s, c})
      {2'd0, 8'd1}: cert = PAYLOAD_W'(`SLOT0_CERT1);
      {2'd0, 8'd2}: cert = PAYLOAD_W'(`SLOT0_CERT2);
      {2'd0, 8'd3}: cert = PAYLOAD_W'(`SLOT0_CERT3);
      {2'd0, 8'd4}: cert = PAYLOAD_W'(`SLOT0_CERT4);
      {2'd0, 8'd5}: cert = PAYLOAD_W'(`SLOT0_CERT5);
      {2'd0, 8'd6}: cert = PAYLOAD_W'(`SLOT0_CERT6);
      {2'd1, 8'd1}: cert = PAYLOAD_W'(`SLOT1_CERT1);
      {2'd1, 8'd2}: cert = PAYLOAD_W'(`SLOT1_CERT2);
      {2'd1, 8'd3}: cert = PAYLOAD_W'(`SLOT1_CERT3);
      {2'd1, 8'd4}: cert = PAYLOAD_W'(`SLOT1_CERT4);
      {2'd2, 8'd1}: cert = PAYLOAD_W'(`SLOT2_CERT1);
      {2'd2, 8'd2}: cert = PAYLOAD_W'(`SLOT2_CERT2);
      {2'd2, 8'd3}: cert = PAYLOAD_W'(`SLOT2_CERT3);
      {2'd2, 8'd4}: cert = PAYLOAD_W'(`SLOT2_CERT4);
      {2'd2, 8'd5}: cert = PAYLOAD_W'(`SLOT2_CERT5);
      default:      cert = '0;
    endcase
  endfunction

  // Single-process FSM; counter_out doubles as the chunk counter (0 when not streaming).
  always_ff @(posedge clk) begin
    if (Reset || !bus.Enable) begin
      state                  <= IDLE;
      slot_q                 <= 2'd0;
      wait_cnt               <= '0;
      bus.Payload_out        <= '0;
      bus.Payload_Valid      <= 1'b0;
      bus.counter_out        <= 8'd0;
      bus.Last_Chunk         <= 1'b0;
      bus.Busy               <= 1'b0;
      bus.Done               <= 1'b0;
      bus.Error_Invalid_Slot <= 1'b0;
      bus.Error_Timeout      <= 1'b0;
    end else begin
      bus.Done               <= 1'b0;
      bus.Error_Invalid_Slot <= 1'b0;
      bus.Error_Timeout      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Request) begin
            bus.Busy <= 1'b1;
            if (bus.slot == 2'd3) begin
              state                  <= ERR;
              bus.Error_Invalid_Slot <= 1'b1;
            end else begin
              state             <= SEND;
              slot_q            <= bus.slot;
              wait_cnt          <= '0;
              bus.Payload_out   <= cert(bus.slot, 8'd1);
              bus.Payload_Valid <= 1'b1;
              bus.counter_out   <= 8'd1;
              bus.Last_Chunk    <= (chain_len(bus.slot) == 8'd1);
            end
          end
        end
        SEND: begin
          if (bus.Payload_Ack) begin
            wait_cnt <= '0;
            if (bus.counter_out == chain_len(slot_q)) begin
              state             <= DONE;
              bus.Payload_out   <= '0;
              bus.Payload_Valid <= 1'b0;
              bus.counter_out   <= 8'd0;
              bus.Last_Chunk    <= 1'b0;
              bus.Done          <= 1'b1;
            end else begin
              bus.Payload_out <= cert(slot_q, bus.counter_out + 8'd1);
              bus.counter_out <= bus.counter_out + 8'd1;
              bus.Last_Chunk  <= (bus.counter_out + 8'd1 == chain_len(slot_q));
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (wait_cnt == WAIT_LAST) begin
              // Chunk expired: drop straight back to IDLE with the error pulse.
              state             <= IDLE;
              wait_cnt          <= '0;
              bus.Payload_out   <= '0;
              bus.Payload_Valid <= 1'b0;
              bus.counter_out   <= 8'd0;
              bus.Last_Chunk    <= 1'b0;
              bus.Busy          <= 1'b0;
              bus.Error_Timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
